// File: rtl/md_unit_if.sv
// Handshake/bus bundle between the E-stage controller and the multiply/divide unit.
// The controller drives the op and operands; the unit returns busy and the HI/LO values.
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, src_a, src_b,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, src_a, src_b,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: fixed-latency mult/multu/div/divu, owns HI/LO.
// The result is formed from operands latched at start and committed on the final busy edge.
module md_unit #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  md
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic [CNT_W-1:0] w_lat;
  logic [63:0]      w_prod_s;
  logic [63:0]      w_prod_u;
  logic [31:0]      w_div_b;
  logic [31:0]      w_abs_a;
  logic [31:0]      w_abs_b;
  logic [31:0]      w_uq;
  logic [31:0]      w_ur;
  logic [31:0]      w_sq_mag;
  logic [31:0]      w_sr_mag;
  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;
  logic             w_wr_en;

  assign md.busy = (r_state == ST_RUN);
  assign md.hi   = r_hi;
  assign md.lo   = r_lo;

  always_comb begin
    w_lat = '0;
    case (md.md_op)
      OP_MULT, OP_MULTU: w_lat = CNT_W'(MULT_LAT);
      OP_DIV,  OP_DIVU:  w_lat = CNT_W'(DIV_LAT);
      default:           w_lat = '0;
    endcase
  end

  assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // A zero divisor is replaced by 1 so the divider never yields X; the write is suppressed anyway.
  assign w_div_b = (r_b == 32'd0) ? 32'd1 : r_b;
  assign w_abs_a = r_a[31] ? (32'd0 - r_a) : r_a;
  assign w_abs_b = w_div_b[31] ? (32'd0 - w_div_b) : w_div_b;

  assign w_uq     = r_a / w_div_b;
  assign w_ur     = r_a % w_div_b;
  assign w_sq_mag = w_abs_a / w_abs_b;
  assign w_sr_mag = w_abs_a % w_abs_b;

  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    w_wr_en  = 1'b0;
    case (r_op)
      OP_MULT: begin
        {w_res_hi, w_res_lo} = w_prod_s;
        w_wr_en = 1'b1;
      end
      OP_MULTU: begin
        {w_res_hi, w_res_lo} = w_prod_u;
        w_wr_en = 1'b1;
      end
      OP_DIV: begin
        // Sign-magnitude division: quotient truncates toward zero, remainder follows the dividend.
        w_res_lo = (r_a[31] ^ r_b[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
        w_res_hi = r_a[31] ? (32'd0 - w_sr_mag) : w_sr_mag;
        w_wr_en  = (r_b != 32'd0);
      end
      OP_DIVU: begin
        w_res_lo = w_uq;
        w_res_hi = w_ur;
        w_wr_en  = (r_b != 32'd0);
      end
      default: w_wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (md.start) begin
            case (md.md_op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_a     <= md.src_a;
                r_b     <= md.src_b;
                r_op    <= md.md_op;
                r_cnt   <= w_lat;
                r_state <= ST_RUN;
              end
              OP_MTHI: r_hi <= md.src_a;
              OP_MTLO: r_lo <= md.src_a;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          // Starts arriving while busy are dropped here rather than queued.
          if (r_cnt == CNT_W'(1)) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            if (w_wr_en) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed and randomized ops against a 64-bit arithmetic model.
module tb_md_unit;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_unit_if u_if ();

  md_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    case (op)
      3'd1: begin
        sa = $signed(a);
        sb = $signed(b);
        q  = sa * sb;
        m_hi = q[63:32];
        m_lo = q[31:0];
      end
      3'd2: begin
        ua = a;
        ub = b;
        p  = ua * ub;
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd3: if (b != 0) begin
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      3'd4: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  // Entered and left on a falling edge; for busy ops, leaves on the first cycle busy is low.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble);
    int n;
    int lat;
    logic [31:0] ph, pl;
    ph = m_hi;
    pl = m_lo;
    u_if.start = 1'b1;
    u_if.md_op = op;
    u_if.src_a = a;
    u_if.src_b = b;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.md_op = 3'd0;
    model(op, a, b);
    if (op >= 3'd1 && op <= 3'd4) begin
      lat = (op <= 3'd2) ? MULT_LAT : DIV_LAT;
      n = 0;
      while (u_if.busy === 1'b1 && n < 40) begin
        if (n == 0) begin
          n_tests++;
          if (u_if.hi !== ph || u_if.lo !== pl) begin
            n_fail++;
            $display("FAIL hold_during_run op=%0d: got hi=%h lo=%h expected hi=%h lo=%h",
                     op, u_if.hi, u_if.lo, ph, pl);
          end
        end
        if (scramble) begin
          u_if.src_a = $urandom;
          u_if.src_b = $urandom;
        end
        n++;
        @(negedge clk);
      end
      n_tests++;
      if (n != lat) begin
        n_fail++;
        $display("FAIL busy_cycles op=%0d: got %0d expected %0d", op, n, lat);
      end
    end else begin
      n_tests++;
      if (u_if.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_nonlat op=%0d: got %b expected 0", op, u_if.busy);
      end
    end
    n_tests++;
    if (u_if.hi !== m_hi || u_if.lo !== m_lo) begin
      n_fail++;
      $display("FAIL result op=%0d a=%h b=%h: got hi=%h lo=%h expected hi=%h lo=%h",
               op, a, b, u_if.hi, u_if.lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (u_if.busy !== 1'b0 || u_if.hi !== 32'd0 || u_if.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b hi=%h lo=%h expected 0 0 0",
               u_if.busy, u_if.hi, u_if.lo);
    end
    reset = 1'b0;
    @(negedge clk);
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic test_directed();
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    n_tests++;
    if (u_if.hi !== 32'hFFFF_FFFF || u_if.lo !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL mult_const: got hi=%h lo=%h expected ffffffff fffffffe", u_if.hi, u_if.lo);
    end
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    n_tests++;
    if (u_if.hi !== 32'h0000_0001 || u_if.lo !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL multu_const: got hi=%h lo=%h expected 00000001 fffffffe", u_if.hi, u_if.lo);
    end
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    n_tests++;
    if (u_if.hi !== 32'hFFFF_FFFF || u_if.lo !== 32'hFFFF_FFFD) begin
      n_fail++;
      $display("FAIL div_const: got hi=%h lo=%h expected ffffffff fffffffd", u_if.hi, u_if.lo);
    end
    run_op(3'd4, 32'd7, 32'd2, 1'b0);
    n_tests++;
    if (u_if.hi !== 32'd1 || u_if.lo !== 32'd3) begin
      n_fail++;
      $display("FAIL divu_const: got hi=%h lo=%h expected 1 3", u_if.hi, u_if.lo);
    end
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    n_tests++;
    if (u_if.hi !== 32'd0 || u_if.lo !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL div_overflow: got hi=%h lo=%h expected 0 80000000", u_if.hi, u_if.lo);
    end
  endtask

  task automatic test_div_zero();
    run_op(3'd5, 32'h11, 32'h0, 1'b0);
    run_op(3'd6, 32'h22, 32'h0, 1'b0);
    run_op(3'd4, 32'd5, 32'd0, 1'b0);
    n_tests++;
    if (u_if.hi !== 32'h11 || u_if.lo !== 32'h22) begin
      n_fail++;
      $display("FAIL divu_by_zero: got hi=%h lo=%h expected 11 22", u_if.hi, u_if.lo);
    end
    run_op(3'd3, 32'hDEAD_BEEF, 32'd0, 1'b0);
    run_op(3'd0, 32'h1234, 32'h5, 1'b0);
    run_op(3'd7, 32'h5678, 32'h5, 1'b0);
  endtask

  task automatic test_ignored_start();
    int n;
    u_if.start = 1'b1;
    u_if.md_op = 3'd1;
    u_if.src_a = 32'h0001_2345;
    u_if.src_b = 32'hFFFF_FF00;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.md_op = 3'd0;
    model(3'd1, 32'h0001_2345, 32'hFFFF_FF00);
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.md_op = 3'd6;
    u_if.src_a = 32'h99;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.md_op = 3'd0;
    n = 2;
    while (u_if.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    n_tests++;
    if (n != MULT_LAT) begin
      n_fail++;
      $display("FAIL ignored_busy_cycles: got %0d expected %0d", n, MULT_LAT);
    end
    n_tests++;
    if (u_if.hi !== m_hi || u_if.lo !== m_lo) begin
      n_fail++;
      $display("FAIL ignored_start: got hi=%h lo=%h expected hi=%h lo=%h",
               u_if.hi, u_if.lo, m_hi, m_lo);
    end
  endtask

  task automatic test_back_to_back();
    run_op(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    run_op(3'd3, 32'd100, 32'hFFFF_FFF9, 1'b1);
    run_op(3'd5, 32'hA5A5_A5A5, 32'd0, 1'b0);
    run_op(3'd2, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1);
    run_op(3'd4, 32'hFFFF_FFFF, 32'd3, 1'b1);
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_op(op, a, b, 1'b1);
    end
  endtask

  task automatic test_reset_midop();
    u_if.start = 1'b1;
    u_if.md_op = 3'd4;
    u_if.src_a = 32'd1000;
    u_if.src_b = 32'd7;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.md_op = 3'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if (u_if.busy !== 1'b0 || u_if.hi !== 32'd0 || u_if.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_async: got busy=%b hi=%h lo=%h expected 0 0 0",
               u_if.busy, u_if.hi, u_if.lo);
    end
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    repeat (DIV_LAT + 4) @(negedge clk);
    n_tests++;
    if (u_if.busy !== 1'b0 || u_if.hi !== 32'd0 || u_if.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_no_late_write: got busy=%b hi=%h lo=%h expected 0 0 0",
               u_if.busy, u_if.hi, u_if.lo);
    end
    run_op(3'd1, 32'd3, 32'd4, 1'b0);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    m_hi       = '0;
    m_lo       = '0;
    reset      = 1'b1;
    u_if.start = 1'b0;
    u_if.md_op = 3'd0;
    u_if.src_a = '0;
    u_if.src_b = '0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_directed();
    test_div_zero();
    test_ignored_start();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
